branch_predictor_btb: RTL
=========================

// Module: branch_predictor_btb
// PURPOSE
//  Dynamic branch predictor for the 5-stage core: direct-mapped BTB plus 2-bit saturating-counter
//  direction table. Predicts taken/target for IF_PC in the same cycle. Uses the branch outcome
//  resolved in EX to train the tables, flag a mispredict and supply the redirect PC.
//  Replaces static EX-resolved branching; the EX compare logic still supplies EX_Taken/EX_Target.
// PARAMETERS
//  INDEX_BITS  4   log2 of table entries (16); index = PC[INDEX_BITS+1:2]
//  TAG_BITS    8   tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
//  CNT_BITS    2   direction counter width; predict taken when MSB=1
//  PERF_WIDTH  32  width of performance counters
// PORTS
//  clk             in   1           core clock
//  rst             in   1           asynchronous reset, active-high
//  IF_PC           in   PC_WIDTH    fetch PC to predict
//  Pred_Hit        out  1           valid entry with matching tag at IF_PC index
//  Pred_Taken      out  1           Pred_Hit && counter MSB
//  Pred_Target     out  PC_WIDTH    stored target (0 when !Pred_Hit)
//  EX_Branch       in   1           EX holds a conditional branch
//  EX_Jump         in   1           EX holds JAL (unconditional); mutually exclusive with EX_Branch
//  EX_PC           in   PC_WIDTH    PC of EX instruction
//  EX_Taken        in   1           resolved direction (ignored when EX_Jump; treated as 1)
//  EX_Target       in   PC_WIDTH    resolved target (EX_PC + EX_Imm)
//  EX_Pred_Taken   in   1           Pred_Taken piped down from IF
//  EX_Pred_Target  in   PC_WIDTH    Pred_Target piped down from IF
//  Mispredict      out  1           EX redirect required this cycle
//  Redirect_PC     out  PC_WIDTH    correct next PC when Mispredict
//  Branch_Count    out  PERF_WIDTH  retired EX_Branch|EX_Jump count
//  Miss_Count      out  PERF_WIDTH  Mispredict count
// BEHAVIOUR
//  - Reset: all valid bits 0, counters = weakly-not-taken (01), tags/targets 0, perf counters 0;
//    outputs: Pred_* = 0, Mispredict = 0, Redirect_PC = 0 when EX_Branch/EX_Jump low.
//  - Lookup: combinational from registered tables, zero-cycle latency. No write->read bypass:
//    an update at posedge N is visible to lookups from cycle N+1 onward.
//  - Resolution (combinational, EX cycle), act = EX_Jump | EX_Taken:
//    Mispredict = (EX_Branch|EX_Jump) & ((act != EX_Pred_Taken) | (act & EX_Target != EX_Pred_Target)).
//    Redirect_PC = act ? EX_Target : EX_PC + 4; driven 0 when Mispredict = 0.
//  - Update (posedge, when EX_Branch|EX_Jump), i/t = index/tag of EX_PC:
//    hit (valid & tag match): counter saturating +1 if act else -1 (no wrap at 11/00);
//      target <= EX_Target if act.
//    miss & act: allocate: valid<=1, tag<=t, target<=EX_Target, counter <= 10 (weakly taken);
//      EX_Jump allocates/sets counter to 11.
//    miss & !act: no table change.
//  - Perf counters: Branch_Count +1 per update cycle, Miss_Count +1 when Mispredict; wrap at
//    2^PERF_WIDTH silently.
//  - Same index looked up and updated in one cycle: lookup returns pre-update contents.
//  - Reset mid-operation: tables and counters clear immediately; prediction state lost.
//  - EX_Branch & EX_Jump both high: illegal; assertion in sim, RTL treats as EX_Jump.
// STRUCTURE
//  - SYSTEM_DEF.vh gains `CNT_WNT (2'b01), `CNT_WT (2'b10), `CNT_ST (2'b11),
//    and `BP_INDEX_BITS/`BP_TAG_BITS defaults; PC_WIDTH reused.
//  - Sub-module sat_counter (CNT_BITS, inc/dec, saturating) instantiated per update path.
//  - Tables as reg arrays (valid, tag, target, cnt); no SRAM macro needed at 16 entries.
// TESTING
//  1 Reset: rst=1 mid-run -> Pred_Hit=0 for every IF_PC, Branch_Count=Miss_Count=0.
//  2 Cold taken BEQ at 0x100 -> target 0x140: Mispredict=1, Redirect_PC=0x140; next lookup of
//    0x100 -> Pred_Hit=1, Pred_Taken=1, Pred_Target=0x140.
//  3 Same branch not-taken twice -> counter 10->01->00; Pred_Taken=0 after first; second
//    resolution no Mispredict; third not-taken holds at 00.
//  4 Alias: 0x100 and 0x140 (same index, diff tag, INDEX_BITS=4) -> 0x140 taken evicts 0x100;
//    lookup 0x100 -> Pred_Hit=0.
//  5 Target change: hit predicted taken to 0x140, resolves taken to 0x180 -> Mispredict=1,
//    Redirect_PC=0x180, table target updated.
//  6 Same-cycle lookup/update of 0x100 -> lookup shows old entry; 1000 branches, 37 misses ->
//    Branch_Count=1000, Miss_Count=37.

Source files
------------

// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants and types for the BTB + 2-bit direction predictor.
// Default geometry plus the encoding of what an EX resolution does to the tables.
package branch_predictor_btb_pkg;

  localparam int BP_INDEX_BITS = 4;
  localparam int BP_TAG_BITS   = 8;
  localparam int BP_PC_WIDTH   = 32;
  localparam int BP_PERF_WIDTH = 32;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_TRAIN = 2'd1,
    UPD_ALLOC = 2'd2
  } upd_e;

  // Hits always train; misses only allocate when the branch actually went somewhere.
  function automatic upd_e upd_sel(input logic vld, input logic hit, input logic act);
    if (!vld)     return UPD_NONE;
    else if (hit) return UPD_TRAIN;
    else if (act) return UPD_ALLOC;
    else          return UPD_NONE;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter step: next value of a direction counter.
// Holds at all-ones when incrementing and at zero when decrementing.
module branch_predictor_btb_sat_counter #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] i_cnt,
  input  logic                i_inc,
  output logic [CNT_BITS-1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_inc) begin
      if (i_cnt != '1) o_cnt = i_cnt + CNT_BITS'(1);
    end else begin
      if (i_cnt != '0) o_cnt = i_cnt - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Same-cycle lookup for fetch; trains from the branch outcome resolved in EX.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int TAG_BITS   = BP_TAG_BITS,
  parameter int CNT_BITS   = 2,
  parameter int PC_WIDTH   = BP_PC_WIDTH,
  parameter int PERF_WIDTH = BP_PERF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   IF_PC,
  output logic                  Pred_Hit,
  output logic                  Pred_Taken,
  output logic [PC_WIDTH-1:0]   Pred_Target,
  input  logic                  EX_Branch,
  input  logic                  EX_Jump,
  input  logic [PC_WIDTH-1:0]   EX_PC,
  input  logic                  EX_Taken,
  input  logic [PC_WIDTH-1:0]   EX_Target,
  input  logic                  EX_Pred_Taken,
  input  logic [PC_WIDTH-1:0]   EX_Pred_Target,
  output logic                  Mispredict,
  output logic [PC_WIDTH-1:0]   Redirect_PC,
  output logic [PERF_WIDTH-1:0] Branch_Count,
  output logic [PERF_WIDTH-1:0] Miss_Count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  localparam logic [CNT_BITS-1:0] L_CNT_WNT = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [CNT_BITS-1:0] L_CNT_WT  = {1'b1, {(CNT_BITS-1){1'b0}}};
  localparam logic [CNT_BITS-1:0] L_CNT_ST  = '1;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] r_target [ENTRIES];
  logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
  logic [PERF_WIDTH-1:0] r_branch_cnt;
  logic [PERF_WIDTH-1:0] r_miss_cnt;

  logic [INDEX_BITS-1:0] w_if_idx, w_ex_idx;
  logic [TAG_BITS-1:0]   w_if_tag, w_ex_tag;
  logic                  w_if_hit, w_ex_hit;
  logic                  w_ex_vld, w_ex_act, w_mis;
  logic [CNT_BITS-1:0]   w_cnt_nxt;
  upd_e                  w_upd;
  logic [PC_WIDTH-TAG_HI:0] w_unused_pc;

  // Only the index/tag window of the fetch PC participates in lookup.
  assign w_unused_pc = {IF_PC[1:0], IF_PC[PC_WIDTH-1:TAG_HI+1]};

  assign w_if_idx = IF_PC[INDEX_BITS+1:2];
  assign w_if_tag = IF_PC[TAG_HI:TAG_LO];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  assign Pred_Hit    = w_if_hit;
  assign Pred_Taken  = w_if_hit & r_cnt[w_if_idx][CNT_BITS-1];
  assign Pred_Target = w_if_hit ? r_target[w_if_idx] : '0;

  assign w_ex_idx = EX_PC[INDEX_BITS+1:2];
  assign w_ex_tag = EX_PC[TAG_HI:TAG_LO];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // A jump is always taken; if both strobes are high the jump interpretation wins.
  assign w_ex_vld = EX_Branch | EX_Jump;
  assign w_ex_act = EX_Jump | EX_Taken;
  assign w_mis    = w_ex_vld & ((w_ex_act != EX_Pred_Taken) |
                                (w_ex_act & (EX_Target != EX_Pred_Target)));

  assign Mispredict  = w_mis;
  assign Redirect_PC = !w_mis ? '0 : (w_ex_act ? EX_Target : EX_PC + PC_WIDTH'(4));

  assign w_upd = upd_sel(w_ex_vld, w_ex_hit, w_ex_act);

  branch_predictor_btb_sat_counter #(.CNT_BITS(CNT_BITS)) u_sat_cnt (
    .i_cnt (r_cnt[w_ex_idx]),
    .i_inc (w_ex_act),
    .o_cnt (w_cnt_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= L_CNT_WNT;
      end
    end else begin
      case (w_upd)
        UPD_TRAIN: begin
          r_cnt[w_ex_idx] <= w_cnt_nxt;
          if (w_ex_act) r_target[w_ex_idx] <= EX_Target;
        end
        UPD_ALLOC: begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= EX_Target;
          r_cnt[w_ex_idx]    <= EX_Jump ? L_CNT_ST : L_CNT_WT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_ex_vld) r_branch_cnt <= r_branch_cnt + PERF_WIDTH'(1);
      if (w_mis)    r_miss_cnt   <= r_miss_cnt + PERF_WIDTH'(1);
    end
  end

  assign Branch_Count = r_branch_cnt;
  assign Miss_Count   = r_miss_cnt;

  a_ex_onehot: assert property (@(posedge clk) disable iff (rst) !(EX_Branch && EX_Jump));

endmodule
